// File: rtl/synapse_obi_loader.sv
// synapse_obi_loader: OBI initiator that copies weight words src -> dst in FIFO_DEPTH batches.
// Optional gnt-stall cycle counter enabled by defining SYNLOADER_STALL_CNT_EN.

typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
} obi_req_t;

typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
} obi_rsp_t;

module synapse_obi_loader #(
    parameter int  FIFO_DEPTH = 4,
    parameter int  LEN_W      = 14,
    parameter type req_t      = obi_req_t,
    parameter type rsp_t      = obi_rsp_t
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      stall_cnt_o,
    output req_t             obi_master_req_o,
    input  rsp_t             obi_master_resp_i
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int AW1 = AW + 1;
    localparam logic [AW:0]      CNT_LAST = AW1'(FIFO_DEPTH - 1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      CNT_ONE  = AW1'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_FIN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_rd_idx;
    logic [LEN_W-1:0] r_wr_idx;
    logic [31:0]      r_buf [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             w_start;
    logic             w_gnt;
    logic             w_rvalid;
    logic             w_push;
    logic             w_pop;
    logic             w_req;
    logic [31:0]      w_rd_off;
    logic [31:0]      w_wr_off;

    assign w_start  = start_i && (r_state == S_IDLE);
    assign w_gnt    = obi_master_resp_i.gnt;
    assign w_rvalid = obi_master_resp_i.rvalid;
    assign w_push   = (r_state == S_RD_WAIT) && w_rvalid;
    assign w_pop    = (r_state == S_WR_REQ) && w_gnt;
    assign w_rd_off = 32'({r_rd_idx, 2'b00});
    assign w_wr_off = 32'({r_wr_idx, 2'b00});

    // State register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode: one outstanding transaction, batch reads then drain
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) w_next = (len_i == '0) ? S_FIN : S_RD_REQ;
            end
            S_RD_REQ: begin
                if (w_gnt) w_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (w_rvalid) begin
                    if (r_cnt == CNT_LAST || (r_rd_idx + LEN_ONE) == r_len)
                        w_next = S_WR_REQ;
                    else
                        w_next = S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                if (w_gnt) w_next = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (w_rvalid) begin
                    if (r_wr_idx == r_len)  w_next = S_FIN;
                    else if (r_cnt == '0)   w_next = S_RD_REQ;
                    else                    w_next = S_WR_REQ;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request outputs: fields derive from registers so they hold while gnt is low
    always_comb begin
        obi_master_req_o    = '0;
        obi_master_req_o.be = 4'hF;
        if (r_state == S_RD_REQ) begin
            obi_master_req_o.req  = 1'b1;
            obi_master_req_o.addr = r_src + w_rd_off;
        end else if (r_state == S_WR_REQ) begin
            obi_master_req_o.req   = 1'b1;
            obi_master_req_o.we    = 1'b1;
            obi_master_req_o.addr  = r_dst + w_wr_off;
            obi_master_req_o.wdata = r_buf[r_rptr];
        end
    end

    assign w_req  = obi_master_req_o.req;
    assign busy_o = r_busy;
    assign done_o = r_done;

    // Transfer bookkeeping: captured parameters, indices, buffer pointers, status
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_rd_idx <= '0;
            r_wr_idx <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);
            if (w_start) begin
                r_src    <= src_addr_i;
                r_dst    <= dst_addr_i;
                r_len    <= len_i;
                r_rd_idx <= '0;
                r_wr_idx <= '0;
                r_wptr   <= '0;
                r_rptr   <= '0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
            end
            if (r_state == S_FIN) r_busy <= 1'b0;
            if (w_push) begin
                r_wptr   <= r_wptr + PTR_ONE;
                r_rd_idx <= r_rd_idx + LEN_ONE;
                r_cnt    <= r_cnt + CNT_ONE;
            end
            if (w_pop) begin
                r_rptr   <= r_rptr + PTR_ONE;
                r_wr_idx <= r_wr_idx + LEN_ONE;
                r_cnt    <= r_cnt - CNT_ONE;
            end
        end
    end

    // Word buffer storage; validity is tracked by the pointers above
    always_ff @(posedge CLK) begin
        if (w_push) r_buf[r_wptr] <= obi_master_resp_i.rdata;
    end

`ifdef SYNLOADER_STALL_CNT_EN
    logic [15:0] r_stall;

    // Saturating count of request cycles left waiting for gnt
    always_ff @(posedge CLK) begin
        if (RST)
            r_stall <= '0;
        else if (w_start)
            r_stall <= '0;
        else if (w_req && !w_gnt && r_stall != 16'hFFFF)
            r_stall <= r_stall + 16'd1;
    end

    assign stall_cnt_o = r_stall;
`else
    assign stall_cnt_o = 16'h0;
`endif

endmodule
